// File: rtl/wb_ram_slave.sv
// Block-RAM Wishbone slave: classic cycles and registered-feedback incrementing
// bursts (linear, wrap-4/8/16), byte-lane writes, err for out-of-range addresses.
module wb_ram_slave #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [29:0] wb_addr_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ACK   = 2'd1;
  localparam logic [1:0]  ST_ERR   = 2'd2;
  localparam logic [2:0]  CTI_INCR = 3'b010;

  logic [31:0] mem [DEPTH];

  logic [1:0]           state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          data_q, data_d;
  logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;

  logic                 req;
  logic                 in_range;
  logic [ADDR_BITS-1:0] idx;
  logic [ADDR_BITS:0]   lin_sum;
  logic [ADDR_BITS-1:0] wrap_mask;
  logic [ADDR_BITS-1:0] next_addr;
  logic                 next_ok;
  logic                 mem_we;

  assign req      = wb_cyc_i & wb_stb_i;
  assign in_range = (wb_addr_i >> ADDR_BITS) == '0;
  assign idx      = wb_addr_i[ADDR_BITS-1:0];
  assign lin_sum  = {1'b0, cur_addr_q} + (ADDR_BITS+1)'(1);

  // Burst address generator; a linear carry out ends the burst.
  always_comb begin
    wrap_mask = '0;
    next_addr = lin_sum[ADDR_BITS-1:0];
    next_ok   = 1'b1;
    case (wb_bte_i)
      2'b01:   wrap_mask = ADDR_BITS'(3);
      2'b10:   wrap_mask = ADDR_BITS'(7);
      2'b11:   wrap_mask = ADDR_BITS'(15);
      default: wrap_mask = '0;
    endcase
    if (wb_bte_i == 2'b00) begin
      next_ok = ~lin_sum[ADDR_BITS];
    end else begin
      next_addr = (cur_addr_q & ~wrap_mask) | (lin_sum[ADDR_BITS-1:0] & wrap_mask);
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    data_d     = data_q;
    cur_addr_d = cur_addr_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!in_range) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            cur_addr_d = idx;
            data_d     = mem[idx];
            ack_d      = 1'b1;
            state_d    = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (req) begin
          mem_we = wb_we_i;
          if (wb_cti_i == CTI_INCR && next_ok) begin
            cur_addr_d = next_addr;
            data_d     = mem[next_addr];
            ack_d      = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      data_q     <= data_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  // Storage is deliberately not reset so contents survive wb_rst_n.
  always_ff @(posedge wb_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we && wb_sel_i[k]) begin
        mem[cur_addr_q][8*k +: 8] <= wb_data_i[8*k +: 8];
      end
    end
  end

  assign wb_data_o = data_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized bench for wb_ram_slave: a word-array model predicts ack/err/data
// every cycle; directed cases pin the model with literal values.
module tb_wb_ram_slave;

  localparam int unsigned AB = 10;
  localparam int unsigned NW = 1 << AB;

  logic        wb_clk;
  logic        wb_rst_n;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [29:0] wb_addr_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic [31:0] wb_data_i;
  logic [31:0] wb_data_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  wb_ram_slave #(.ADDR_BITS(AB)) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_addr_i (wb_addr_i),
    .wb_cti_i  (wb_cti_i),
    .wb_bte_i  (wb_bte_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_data_i (wb_data_i),
    .wb_data_o (wb_data_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m  [NW];
  bit          mvalid [NW];

  logic        chk_en  = 1'b0;
  logic        exp_ack = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_dv  = 1'b0;
  logic [31:0] exp_data = '0;

  logic [31:0] cap [64];
  int          cap_n;
  logic        last_err;

  // Per-cycle comparison against the model's expectation for this cycle.
  always @(negedge wb_clk) begin
    if (chk_en) begin
      total++;
      if (wb_ack_o !== exp_ack) begin
        bad++;
        $display("FAIL ack @%0t: got %b want %b", $time, wb_ack_o, exp_ack);
      end
      total++;
      if (wb_err_o !== exp_err) begin
        bad++;
        $display("FAIL err @%0t: got %b want %b", $time, wb_err_o, exp_err);
      end
      if (exp_ack && exp_dv) begin
        total++;
        if (wb_data_o !== exp_data) begin
          bad++;
          $display("FAIL rdata @%0t: got %h want %h", $time, wb_data_o, exp_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_cti_i = 3'b000;
  endtask

  task automatic model_next(input int cur, input logic [1:0] bte, output int nxt, output logic ok);
    int n;
    if (bte == 2'b00) begin
      nxt = cur + 1;
      ok  = (nxt < int'(NW));
    end else begin
      n   = 2 << bte;
      nxt = (cur / n) * n + (cur + 1) % n;
      ok  = 1'b1;
    end
  endtask

  // Master with registered feedback; drives one transfer and sets expectations.
  task automatic run_burst(input logic [29:0] start, input logic we, input logic [1:0] bte,
                           input int len, input logic [2:0] last_cti, input int abandon_at,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           input logic rnd_data, input logic rnd_sel);
    int k;
    int cur;
    int nxt;
    logic ok;
    cap_n    = 0;
    last_err = 1'b0;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_addr_i = start;
    wb_we_i   = we;
    wb_bte_i  = bte;
    wb_sel_i  = rnd_sel ? 4'($urandom) : sel;
    wb_data_i = rnd_data ? $urandom : wdata;
    wb_cti_i  = (len <= 1) ? last_cti : 3'b010;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    tick();
    if ((start >> AB) != 0) begin
      exp_err  = 1'b1;
      last_err = wb_err_o;
      idle_bus();
      tick();
      exp_err = 1'b0;
      return;
    end
    cur = int'(start);
    k   = 0;
    forever begin
      exp_ack  = 1'b1;
      exp_dv   = mvalid[cur];
      exp_data = mem_m[cur];
      if (k < 64) cap[k] = wb_data_o;
      cap_n = k + 1;
      if (k == abandon_at) begin
        idle_bus();
        tick();
        exp_ack = 1'b0;
        break;
      end
      tick();
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (wb_sel_i[b]) mem_m[cur][8*b +: 8] = wb_data_i[8*b +: 8];
        if (wb_sel_i == 4'hf) mvalid[cur] = 1'b1;
      end
      model_next(cur, bte, nxt, ok);
      if (wb_cti_i == 3'b010 && ok) begin
        cur = nxt;
        k++;
        wb_addr_i = 30'($urandom);
        wb_data_i = rnd_data ? $urandom : wdata;
        if (rnd_sel) wb_sel_i = 4'($urandom);
        wb_cti_i = (k >= len - 1) ? last_cti : 3'b010;
      end else begin
        idle_bus();
        exp_ack = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] a;
    int          len;
    int          ab;
    logic [2:0]  lc;

    wb_rst_n  = 1'b0;
    wb_addr_i = '0;
    wb_bte_i  = 2'b00;
    wb_sel_i  = 4'h0;
    wb_data_i = '0;
    idle_bus();
    repeat (3) tick();
    check("reset_ack", 32'(wb_ack_o), 32'h0);
    check("reset_err", 32'(wb_err_o), 32'h0);
    check("reset_data", wb_data_o, 32'h0);
    wb_rst_n = 1'b1;
    chk_en   = 1'b1;
    tick();

    // Fill the whole memory with one linear write burst.
    run_burst(30'h0, 1'b1, 2'b00, int'(NW), 3'b111, -1, 32'h0, 4'hf, 1'b1, 1'b0);
    check("fill_beats", 32'(cap_n), 32'(NW));

    run_burst(30'h010, 1'b1, 2'b00, 1, 3'b000, -1, 32'hDEADBEEF, 4'hf, 1'b0, 1'b0);
    run_burst(30'h010, 1'b0, 2'b00, 1, 3'b000, -1, 32'h0, 4'hf, 1'b0, 1'b0);
    check("classic_rd", cap[0], 32'hDEADBEEF);

    run_burst(30'h020, 1'b1, 2'b00, 1, 3'b000, -1, 32'hAAAAAAAA, 4'hf, 1'b0, 1'b0);
    run_burst(30'h020, 1'b1, 2'b00, 1, 3'b000, -1, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    run_burst(30'h020, 1'b0, 2'b00, 1, 3'b000, -1, 32'h0, 4'hf, 1'b0, 1'b0);
    check("byte_lanes", cap[0], 32'hAA22AA44);

    for (int i = 4; i < 8; i++)
      run_burst(30'(i), 1'b1, 2'b00, 1, 3'b111, -1, 32'hA5A50000 | 32'(i), 4'hf, 1'b0, 1'b0);
    run_burst(30'h006, 1'b0, 2'b01, 4, 3'b111, -1, 32'h0, 4'hf, 1'b0, 1'b0);
    check("wrap4_beats", 32'(cap_n), 32'd4);
    check("wrap4_b0", cap[0], 32'hA5A50006);
    check("wrap4_b1", cap[1], 32'hA5A50007);
    check("wrap4_b2", cap[2], 32'hA5A50004);
    check("wrap4_b3", cap[3], 32'hA5A50005);

    run_burst(30'h3FE, 1'b0, 2'b00, 5, 3'b111, -1, 32'h0, 4'hf, 1'b0, 1'b0);
    check("top_beats", 32'(cap_n), 32'd2);
    run_burst(30'h400, 1'b0, 2'b00, 1, 3'b000, -1, 32'h0, 4'hf, 1'b0, 1'b0);
    check("top_reissue_err", 32'(last_err), 32'h1);
    check("top_reissue_noack", 32'(cap_n), 32'h0);

    run_burst(30'h000, 1'b1, 2'b00, 1, 3'b000, -1, 32'h0BADF00D, 4'hf, 1'b0, 1'b0);
    run_burst(30'h00001000, 1'b1, 2'b00, 1, 3'b000, -1, 32'h55555555, 4'hf, 1'b0, 1'b0);
    check("oor_err", 32'(last_err), 32'h1);
    run_burst(30'h000, 1'b0, 2'b00, 1, 3'b000, -1, 32'h0, 4'hf, 1'b0, 1'b0);
    check("oor_unchanged", cap[0], 32'h0BADF00D);

    // Reset during the third beat of a linear write burst.
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_addr_i = 30'h100;
    wb_we_i   = 1'b1;
    wb_sel_i  = 4'hf;
    wb_bte_i  = 2'b00;
    wb_cti_i  = 3'b010;
    wb_data_i = 32'hC0DE0000;
    exp_ack   = 1'b0;
    tick();
    for (int b = 0; b < 2; b++) begin
      exp_ack  = 1'b1;
      exp_dv   = mvalid[256 + b];
      exp_data = mem_m[256 + b];
      tick();
      mem_m[256 + b] = wb_data_i;
      wb_data_i = 32'hC0DE0001 + 32'(b);
    end
    exp_ack  = 1'b1;
    exp_dv   = mvalid[258];
    exp_data = mem_m[258];
    @(negedge wb_clk);
    #1;
    wb_rst_n = 1'b0;
    exp_ack  = 1'b0;
    #1;
    check("rst_mid_ack", 32'(wb_ack_o), 32'h0);
    check("rst_mid_err", 32'(wb_err_o), 32'h0);
    tick();
    idle_bus();
    #2;
    wb_rst_n = 1'b1;
    tick();
    run_burst(30'h101, 1'b0, 2'b00, 1, 3'b000, -1, 32'h0, 4'hf, 1'b0, 1'b0);
    check("rst_prev_beat", cap[0], 32'hC0DE0001);
    run_burst(30'h102, 1'b0, 2'b00, 1, 3'b000, -1, 32'h0, 4'hf, 1'b0, 1'b0);
    check("rst_beat3_old", cap[0], mem_m[258]);

    // Random transfers: mixed bursts, end codes, abandons and bad addresses.
    for (int t = 0; t < 300; t++) begin
      a = 30'($urandom_range(0, 1279));
      if ($urandom_range(0, 15) == 0) a = 30'($urandom);
      len = $urandom_range(1, 20);
      lc  = 3'($urandom_range(0, 6));
      if (lc >= 3'd2) lc = lc + 3'd1;
      ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      run_burst(a, 1'($urandom), 2'($urandom), len, lc, ab, 32'h0, 4'hf, 1'b1, 1'b1);
    end

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
